// File: rtl/cpu_types_pkg.sv
// Shared types for the cache/memory subsystem: bus word, RAM handshake states,
// responder FSM states and the arbiter's one-hot grant bit positions.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'b00,
    BUSY   = 2'b01,
    ACCESS = 2'b10,
    ERROR  = 2'b11
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    IREAD  = 2'b01,
    DREAD  = 2'b10,
    DWRITE = 2'b11
  } respstate_t;

  localparam word_t ERR_WORD_DEFAULT = 32'hBAD1BAD1;

  // Bit positions inside the arbiter's one-hot grant vector
  localparam int GNT_I  = 0;
  localparam int GNT_DR = 1;
  localparam int GNT_DW = 2;

endpackage

// File: rtl/cache_mem_responder_if.sv
// Cache-side request/response signals plus the RAM port, bundled for the responder.
// master = requesters and RAM model side, slave = the responder.
interface cache_mem_responder_if;
  import cpu_types_pkg::*;

  logic      iREN;
  word_t     iaddr;
  logic      iwait;
  word_t     iload;

  logic      dREN;
  logic      dWEN;
  word_t     daddr;
  word_t     dstore;
  logic      dwait;
  word_t     dload;

  logic      ramREN;
  logic      ramWEN;
  word_t     ramaddr;
  word_t     ramstore;
  word_t     ramload;
  ramstate_t ramstate;

  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
  );

  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
  );

endinterface

// File: rtl/mem_arb_grant.sv
// Fixed-priority pick (write > read > instruction) with a starvation override that
// hands the port to the instruction side after STARVE_LIMIT back-to-back data grants.
module mem_arb_grant
  import cpu_types_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       grant_en,
  input  logic       iren,
  input  logic       dren,
  input  logic       dwen,
  output logic [2:0] grant
);
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  logic [SW-1:0] starve_cnt_reg, starve_cnt_next;
  logic          starved;
  logic          any_grant;

  assign starved   = iren && (starve_cnt_reg == SW'(STARVE_LIMIT));
  assign any_grant = |grant;

  always_comb begin
    grant = '0;
    if (grant_en) begin
      if (starved)   grant[GNT_I]  = 1'b1;
      else if (dwen) grant[GNT_DW] = 1'b1;
      else if (dren) grant[GNT_DR] = 1'b1;
      else if (iren) grant[GNT_I]  = 1'b1;
    end
  end

  // Count only data grants that actually bypassed a waiting instruction fetch
  always_comb begin
    starve_cnt_next = starve_cnt_reg;
    if (any_grant) begin
      if (grant[GNT_I] || !iren)
        starve_cnt_next = '0;
      else if (starve_cnt_reg != SW'(STARVE_LIMIT))
        starve_cnt_next = starve_cnt_reg + SW'(1);
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) starve_cnt_reg <= '0;
    else     starve_cnt_reg <= starve_cnt_next;
  end

endmodule

// File: rtl/cache_mem_responder.sv
// Memory-side responder: serialises icache/dcache accesses onto one RAM port and
// completes each on RAM ACCESS, on RAM ERROR, or after TIMEOUT busy cycles.
module cache_mem_responder
  import cpu_types_pkg::*;
#(
  parameter int    STARVE_LIMIT = 4,
  parameter int    TIMEOUT      = 255,
  parameter word_t ERR_WORD     = ERR_WORD_DEFAULT
) (
  input  logic                  CLK,
  input  logic                  RST,
  cache_mem_responder_if.slave  cmif,
  output logic                  err
);
  localparam int TW = $clog2(TIMEOUT + 1);

  respstate_t    state_reg, state_next;
  word_t         addr_reg, store_reg;
  logic [TW-1:0] tmo_cnt_reg;
  logic          err_reg;
  logic [2:0]    grant;

  logic  idle, busy, req_live, timed_out;
  logic  done_ok, done_fail, abort, complete;
  word_t read_word;

  assign idle = (state_reg == IDLE);
  assign busy = !idle;

  mem_arb_grant #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_grant (
    .CLK      (CLK),
    .RST      (RST),
    .grant_en (idle),
    .iren     (cmif.iREN),
    .dren     (cmif.dREN),
    .dwen     (cmif.dWEN),
    .grant    (grant)
  );

  always_comb begin
    req_live = 1'b0;
    case (state_reg)
      IREAD:   req_live = cmif.iREN;
      DREAD:   req_live = cmif.dREN;
      DWRITE:  req_live = cmif.dWEN;
      default: req_live = 1'b0;
    endcase
  end

  // ACCESS always completes; otherwise a withdrawn request aborts before any failure
  assign timed_out = (tmo_cnt_reg == TW'(TIMEOUT));
  assign done_ok   = busy && (cmif.ramstate == ACCESS);
  assign abort     = busy && !done_ok && !req_live;
  assign done_fail = busy && !done_ok && !abort &&
                     ((cmif.ramstate == ERROR) || timed_out);
  assign complete  = done_ok || done_fail;
  assign read_word = done_ok ? cmif.ramload : ERR_WORD;

  always_comb begin
    state_next = state_reg;
    if (idle) begin
      if (grant[GNT_DW])      state_next = DWRITE;
      else if (grant[GNT_DR]) state_next = DREAD;
      else if (grant[GNT_I])  state_next = IREAD;
    end else if (complete || abort) begin
      state_next = IDLE;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_reg   <= IDLE;
      addr_reg    <= '0;
      store_reg   <= '0;
      tmo_cnt_reg <= '0;
      err_reg     <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (idle && (|grant)) begin
        addr_reg <= grant[GNT_I] ? cmif.iaddr : cmif.daddr;
        if (grant[GNT_DW]) store_reg <= cmif.dstore;
      end
      if (busy && !complete && !abort) tmo_cnt_reg <= tmo_cnt_reg + TW'(1);
      else                             tmo_cnt_reg <= '0;
      if (done_fail) err_reg <= 1'b1;
    end
  end

  always_comb begin
    cmif.iwait    = 1'b1;
    cmif.dwait    = 1'b1;
    cmif.iload    = '0;
    cmif.dload    = '0;
    cmif.ramREN   = 1'b0;
    cmif.ramWEN   = 1'b0;
    cmif.ramaddr  = '0;
    cmif.ramstore = '0;
    case (state_reg)
      IREAD: begin
        cmif.ramREN  = 1'b1;
        cmif.ramaddr = addr_reg;
        if (complete) begin
          cmif.iwait = 1'b0;
          cmif.iload = read_word;
        end
      end
      DREAD: begin
        cmif.ramREN  = 1'b1;
        cmif.ramaddr = addr_reg;
        if (complete) begin
          cmif.dwait = 1'b0;
          cmif.dload = read_word;
        end
      end
      DWRITE: begin
        cmif.ramWEN   = 1'b1;
        cmif.ramaddr  = addr_reg;
        cmif.ramstore = store_reg;
        if (complete) begin
          cmif.dwait = 1'b0;
          cmif.dload = done_ok ? word_t'(0) : ERR_WORD;
        end
      end
      default: ;
    endcase
  end

  assign err = err_reg;

endmodule

// File: tb/tb_cache_mem_responder.sv
// Directed scenarios followed by randomized transactions against a transaction-level model.
module tb_cache_mem_responder;
  import cpu_types_pkg::*;

  localparam logic [31:0] BAD = 32'hBAD1BAD1;

  logic CLK = 1'b0;
  logic RST;
  logic err;
  int   n_checks = 0;
  int   n_fail   = 0;

  cache_mem_responder_if dut_if ();

  cache_mem_responder dut (
    .CLK  (CLK),
    .RST  (RST),
    .cmif (dut_if),
    .err  (err)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic next_cyc();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // model state for the random phase
  int          sc, win, nbusy, done_k;
  bit          pend_i, pend_d, d_wr, err_exp;
  logic [31:0] ia, da, ds, rl, tmo_load, exp_i, exp_d;
  ramstate_t   fin;

  initial begin
    RST = 1'b1;
    dut_if.iREN = 0; dut_if.iaddr = 0; dut_if.dREN = 0; dut_if.dWEN = 0;
    dut_if.daddr = 0; dut_if.dstore = 0; dut_if.ramload = 0; dut_if.ramstate = FREE;

    // reset state
    @(negedge CLK);
    chk("rst_iwait", dut_if.iwait, 1);    chk("rst_dwait", dut_if.dwait, 1);
    chk("rst_iload", dut_if.iload, 0);    chk("rst_dload", dut_if.dload, 0);
    chk("rst_ramREN", dut_if.ramREN, 0);  chk("rst_ramWEN", dut_if.ramWEN, 0);
    chk("rst_ramaddr", dut_if.ramaddr, 0); chk("rst_ramstore", dut_if.ramstore, 0);
    chk("rst_err", err, 0);
    next_cyc();
    RST = 1'b0;

    // single instruction read
    dut_if.iREN = 1; dut_if.iaddr = 32'h40;
    @(negedge CLK); chk("sr_idle_iwait", dut_if.iwait, 1);
    next_cyc();
    dut_if.ramstate = ACCESS; dut_if.ramload = 32'h8C220004;
    @(negedge CLK);
    chk("sr_ramREN", dut_if.ramREN, 1); chk("sr_ramaddr", dut_if.ramaddr, 32'h40);
    chk("sr_iwait", dut_if.iwait, 0);   chk("sr_iload", dut_if.iload, 32'h8C220004);
    chk("sr_dwait", dut_if.dwait, 1);
    next_cyc();
    dut_if.iREN = 0; dut_if.ramstate = FREE;
    @(negedge CLK); chk("sr_after_iwait", dut_if.iwait, 1); chk("sr_after_ramREN", dut_if.ramREN, 0);
    $display("txn single_read done");
    next_cyc();

    // contention: data first, then instruction
    dut_if.iREN = 1; dut_if.iaddr = 32'h40; dut_if.dREN = 1; dut_if.daddr = 32'h200;
    @(negedge CLK);
    next_cyc();
    dut_if.ramstate = ACCESS; dut_if.ramload = 32'h11112222;
    @(negedge CLK);
    chk("ct_d_addr", dut_if.ramaddr, 32'h200); chk("ct_dwait", dut_if.dwait, 0);
    chk("ct_dload", dut_if.dload, 32'h11112222); chk("ct_iwait_hi", dut_if.iwait, 1);
    next_cyc();
    dut_if.dREN = 0; dut_if.ramstate = FREE;
    @(negedge CLK); chk("ct_idle_iwait", dut_if.iwait, 1);
    next_cyc();
    dut_if.ramstate = ACCESS; dut_if.ramload = 32'h33334444;
    @(negedge CLK);
    chk("ct_i_addr", dut_if.ramaddr, 32'h40); chk("ct_iwait", dut_if.iwait, 0);
    chk("ct_iload", dut_if.iload, 32'h33334444); chk("ct_dwait_hi", dut_if.dwait, 1);
    next_cyc();
    dut_if.iREN = 0; dut_if.ramstate = FREE;
    $display("txn contention done");

    // starvation: both held, instruction forced on 5th grant
    dut_if.iREN = 1; dut_if.iaddr = 32'h80; dut_if.dREN = 1; dut_if.daddr = 32'h300;
    for (int g = 1; g <= 5; g++) begin
      @(negedge CLK);
      next_cyc();
      dut_if.ramstate = ACCESS; dut_if.ramload = 32'(g);
      @(negedge CLK);
      chk($sformatf("starve_addr_g%0d", g), dut_if.ramaddr, (g == 5) ? 32'h80 : 32'h300);
      next_cyc();
      dut_if.ramstate = FREE;
      $display("txn starve grant %0d", g);
    end
    dut_if.iREN = 0; dut_if.dREN = 0;

    // write beats read
    dut_if.dWEN = 1; dut_if.dREN = 1; dut_if.daddr = 32'h100; dut_if.dstore = 32'hDEADBEEF;
    @(negedge CLK);
    next_cyc();
    dut_if.ramstate = BUSY;
    @(negedge CLK);
    chk("wr_ramWEN", dut_if.ramWEN, 1); chk("wr_ramREN", dut_if.ramREN, 0);
    chk("wr_ramaddr", dut_if.ramaddr, 32'h100); chk("wr_ramstore", dut_if.ramstore, 32'hDEADBEEF);
    chk("wr_busy_dwait", dut_if.dwait, 1);
    next_cyc();
    dut_if.ramstate = ACCESS;
    @(negedge CLK); chk("wr_dwait", dut_if.dwait, 0);
    next_cyc();
    dut_if.dWEN = 0; dut_if.dREN = 0; dut_if.ramstate = FREE;
    $display("txn write done");

    // RAM ERROR on instruction read, err sticky afterwards
    dut_if.iREN = 1; dut_if.iaddr = 32'h44;
    @(negedge CLK);
    next_cyc();
    dut_if.ramstate = ERROR;
    @(negedge CLK); chk("er_iwait", dut_if.iwait, 0); chk("er_iload", dut_if.iload, BAD);
    next_cyc();
    dut_if.ramstate = FREE; dut_if.iaddr = 32'h48;
    @(negedge CLK); chk("er_err_set", err, 1);
    next_cyc();
    dut_if.ramstate = ACCESS; dut_if.ramload = 32'h55;
    @(negedge CLK); chk("er_good_iload", dut_if.iload, 32'h55); chk("er_err_keep", err, 1);
    next_cyc();
    dut_if.iREN = 0; dut_if.ramstate = FREE;
    @(negedge CLK); chk("er_err_keep2", err, 1);
    $display("txn ram_error done");

    // timeout with RAM stuck BUSY
    next_cyc();
    RST = 1;
    @(negedge CLK); chk("to_rst_err", err, 0);
    next_cyc();
    RST = 0; dut_if.iREN = 1; dut_if.iaddr = 32'h4C;
    @(negedge CLK);
    next_cyc();
    dut_if.ramstate = BUSY;
    done_k = 0; tmo_load = 0;
    for (int k = 1; k <= 400; k++) begin
      @(negedge CLK);
      if (dut_if.iwait === 1'b0) begin
        done_k = k; tmo_load = dut_if.iload;
        break;
      end
      next_cyc();
    end
    chk("to_cycle", done_k, 256); chk("to_iload", tmo_load, BAD);
    next_cyc();
    dut_if.iREN = 0; dut_if.ramstate = FREE;
    @(negedge CLK); chk("to_err", err, 1);
    $display("txn timeout done after %0d busy cycles", done_k);

    // reset asserted mid data read
    next_cyc();
    dut_if.dREN = 1; dut_if.daddr = 32'h500;
    @(negedge CLK);
    next_cyc();
    dut_if.ramstate = BUSY;
    @(negedge CLK);
    next_cyc();
    RST = 1;
    #1;
    chk("mr_dwait", dut_if.dwait, 1); chk("mr_ramREN", dut_if.ramREN, 0); chk("mr_err", err, 0);
    @(negedge CLK);
    next_cyc();
    RST = 0; dut_if.ramstate = FREE;
    @(negedge CLK);
    next_cyc();
    dut_if.ramstate = ACCESS; dut_if.ramload = 32'h77;
    @(negedge CLK); chk("mr_after_dwait", dut_if.dwait, 0); chk("mr_after_dload", dut_if.dload, 32'h77);
    next_cyc();
    dut_if.dREN = 0; dut_if.ramstate = FREE;
    $display("txn reset_mid_read done");

    // withdrawal while BUSY
    dut_if.dREN = 1; dut_if.daddr = 32'h600;
    @(negedge CLK);
    next_cyc();
    dut_if.ramstate = BUSY;
    @(negedge CLK); chk("wd_ramREN", dut_if.ramREN, 1);
    next_cyc();
    dut_if.dREN = 0;
    @(negedge CLK); chk("wd_no_ack", dut_if.dwait, 1);
    next_cyc();
    @(negedge CLK);
    chk("wd_ramREN_drop", dut_if.ramREN, 0); chk("wd_dwait", dut_if.dwait, 1); chk("wd_err", err, 0);
    next_cyc();
    dut_if.ramstate = FREE;
    $display("txn withdrawal done");

    // randomized transactions against the transaction-level model
    RST = 1;
    next_cyc();
    RST = 0;
    sc = 0; pend_i = 0; pend_d = 0; d_wr = 0; err_exp = 0; ia = 0; da = 0; ds = 0;
    for (int t = 0; t < 80; t++) begin
      if (!pend_i && $urandom_range(0, 2) != 0) begin
        pend_i = 1; ia = $urandom() & 32'hFFFF_FFFC;
      end
      if (!pend_d && ($urandom_range(0, 2) != 0 || !pend_i)) begin
        pend_d = 1; d_wr = ($urandom_range(0, 1) == 1);
        da = $urandom() & 32'hFFFF_FFFC; ds = $urandom();
      end
      dut_if.iREN = pend_i; dut_if.iaddr = ia;
      dut_if.dWEN = pend_d && d_wr;
      dut_if.dREN = pend_d && (!d_wr || ($urandom_range(0, 1) == 1));
      dut_if.daddr = da; dut_if.dstore = ds;

      if (pend_i && sc == 4) win = 0;
      else if (pend_d)       win = d_wr ? 2 : 1;
      else                   win = 0;
      if (win == 0)    sc = 0;
      else if (pend_i) sc = (sc < 4) ? sc + 1 : 4;
      else             sc = 0;

      nbusy = $urandom_range(0, 3);
      fin   = ($urandom_range(0, 7) == 0) ? ERROR : ACCESS;
      rl    = $urandom();

      @(negedge CLK);
      chk("rnd_idle_waits", {dut_if.iwait, dut_if.dwait}, 2'b11);
      chk("rnd_err", err, err_exp);
      next_cyc();
      for (int b = 0; b < nbusy; b++) begin
        dut_if.ramstate = ($urandom_range(0, 1) == 0) ? BUSY : FREE;
        @(negedge CLK);
        chk("rnd_strobes", {dut_if.ramREN, dut_if.ramWEN}, (win == 2) ? 2'b01 : 2'b10);
        chk("rnd_ramaddr", dut_if.ramaddr, (win == 0) ? ia : da);
        if (win == 2) chk("rnd_ramstore", dut_if.ramstore, ds);
        chk("rnd_busy_waits", {dut_if.iwait, dut_if.dwait}, 2'b11);
        next_cyc();
      end
      dut_if.ramstate = fin; dut_if.ramload = rl;
      exp_i = 0; exp_d = 0;
      if (win == 0)      exp_i = (fin == ACCESS) ? rl : BAD;
      else if (win == 1) exp_d = (fin == ACCESS) ? rl : BAD;
      else               exp_d = (fin == ACCESS) ? 32'h0 : BAD;
      @(negedge CLK);
      chk("rnd_done_waits", {dut_if.iwait, dut_if.dwait}, (win == 0) ? 2'b01 : 2'b10);
      chk("rnd_iload", dut_if.iload, exp_i);
      chk("rnd_dload", dut_if.dload, exp_d);
      $display("txn rnd %0d win=%0d busy=%0d fin=%0d", t, win, nbusy, fin);
      next_cyc();
      dut_if.ramstate = FREE;
      if (fin == ERROR) err_exp = 1;
      if (win == 0) pend_i = 0;
      else          pend_d = 0;
      dut_if.iREN = pend_i; dut_if.dREN = pend_d && !d_wr; dut_if.dWEN = pend_d && d_wr;
    end
    @(negedge CLK);
    chk("rnd_final_err", err, err_exp);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
